id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_pkg.sv | 27 ++
 rtl/forwarding_unit.sv | 22 ++
 rtl/mux2_n.sv | 13 +
 rtl/id_ex_stage.sv | 186 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared defines for the ID/EX pipeline stage: ALU operation codes and forward-select encodings.
// Also holds the forwarding match rule shared by both operand forwarding units.
package id_ex_stage_pkg;

   localparam logic [3:0] AluAdd  = 4'h0;
   localparam logic [3:0] AluSub  = 4'h1;
   localparam logic [3:0] AluAnd  = 4'h2;
   localparam logic [3:0] AluOr   = 4'h3;
   localparam logic [3:0] AluXor  = 4'h4;
   localparam logic [3:0] AluSll  = 4'h5;
   localparam logic [3:0] AluSrl  = 4'h6;
   localparam logic [3:0] AluSra  = 4'h7;
   localparam logic [3:0] AluSlt  = 4'h8;
   localparam logic [3:0] AluSltu = 4'h9;

   typedef enum logic [1:0] {
      FwdNone  = 2'b00,
      FwdExMem = 2'b01,
      FwdMemWb = 2'b10
   } fwd_sel_e;

   // x0 is hardwired to zero, so a write to it must never be forwarded.
   function automatic logic fwd_hit(input logic [4:0] rd, input logic wr, input logic [4:0] rs);
      return wr && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Picks the forwarding source for one ALU operand; EX/MEM outranks MEM/WB.
module forwarding_unit
   import id_ex_stage_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] exmem_rd,
   input  logic       exmem_reg_write,
   input  logic [4:0] memwb_rd,
   input  logic       memwb_reg_write,
   output logic [1:0] sel
);

   always_comb begin
      sel = FwdNone;
      if (fwd_hit(exmem_rd, exmem_reg_write, rs)) begin
         sel = FwdExMem;
      end else if (fwd_hit(memwb_rd, memwb_reg_write, rs)) begin
         sel = FwdMemWb;
      end
   end

endmodule

// File: rtl/mux2_n.sv
// N-bit 2:1 multiplexer.
module mux2_n #(
   parameter int unsigned N = 32
) (
   input  logic         sel_i,
   input  logic [N-1:0] d0_i,
   input  logic [N-1:0] d1_i,
   output logic [N-1:0] y_o
);

   assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles and operand forwarding.
// Forwarding is combinational on the registered slot plus the live EX/MEM and MEM/WB inputs.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         id_valid,
   input  logic [N-1:0] id_rs1_data,
   input  logic [N-1:0] id_rs2_data,
   input  logic [N-1:0] id_imm,
   input  logic [4:0]   id_rs1,
   input  logic [4:0]   id_rs2,
   input  logic [4:0]   id_rd,
   input  logic [3:0]   id_alu_control,
   input  logic         id_alu_src,
   input  logic         id_reg_write,
   input  logic         id_mem_read,
   input  logic         id_mem_write,
   input  logic         branch_flush,
   input  logic         exmem_reg_write,
   input  logic         memwb_reg_write,
   input  logic [4:0]   exmem_rd,
   input  logic [4:0]   memwb_rd,
   input  logic [N-1:0] exmem_result,
   input  logic [N-1:0] memwb_result,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_control_out,
   output logic [N-1:0] store_data,
   output logic [4:0]   rd_out,
   output logic         reg_write_out,
   output logic         mem_read_out,
   output logic         mem_write_out,
   output logic         valid_out,
   output logic         stall_out
);

   logic         valid_q, valid_d;
   logic [N-1:0] rs1_data_q, rs1_data_d;
   logic [N-1:0] rs2_data_q, rs2_data_d;
   logic [N-1:0] imm_q, imm_d;
   logic [4:0]   rs1_q, rs1_d;
   logic [4:0]   rs2_q, rs2_d;
   logic [4:0]   rd_q, rd_d;
   logic [3:0]   alu_control_q, alu_control_d;
   logic         alu_src_q, alu_src_d;
   logic         reg_write_q, reg_write_d;
   logic         mem_read_q, mem_read_d;
   logic         mem_write_q, mem_write_d;

   logic         load_use;
   logic         bubble;
   logic [1:0]   sel_a, sel_b;
   logic [N-1:0] a_wb, b_wb, fwd_a, fwd_b;

   assign load_use = valid_q & mem_read_q & (rd_q != 5'd0) & id_valid &
                     ((rd_q == id_rs1) | (rd_q == id_rs2));
   assign stall_out = load_use & ~branch_flush;
   assign bubble = branch_flush | load_use;

   always_comb begin
      valid_d       = id_valid;
      rs1_data_d    = id_rs1_data;
      rs2_data_d    = id_rs2_data;
      imm_d         = id_imm;
      rs1_d         = id_rs1;
      rs2_d         = id_rs2;
      rd_d          = id_rd;
      alu_control_d = id_alu_control;
      alu_src_d     = id_alu_src;
      reg_write_d   = id_reg_write;
      mem_read_d    = id_mem_read;
      mem_write_d   = id_mem_write;
      if (bubble) begin
         valid_d       = 1'b0;
         rs1_data_d    = '0;
         rs2_data_d    = '0;
         imm_d         = '0;
         rs1_d         = '0;
         rs2_d         = '0;
         rd_d          = '0;
         alu_control_d = '0;
         alu_src_d     = 1'b0;
         reg_write_d   = 1'b0;
         mem_read_d    = 1'b0;
         mem_write_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q       <= 1'b0;
         rs1_data_q    <= '0;
         rs2_data_q    <= '0;
         imm_q         <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         alu_control_q <= '0;
         alu_src_q     <= 1'b0;
         reg_write_q   <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
      end else begin
         valid_q       <= valid_d;
         rs1_data_q    <= rs1_data_d;
         rs2_data_q    <= rs2_data_d;
         imm_q         <= imm_d;
         rs1_q         <= rs1_d;
         rs2_q         <= rs2_d;
         rd_q          <= rd_d;
         alu_control_q <= alu_control_d;
         alu_src_q     <= alu_src_d;
         reg_write_q   <= reg_write_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
      end
   end

   forwarding_unit u_fwd_a (
      .rs              (rs1_q),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .sel             (sel_a)
   );

   forwarding_unit u_fwd_b (
      .rs              (rs2_q),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .sel             (sel_b)
   );

   // Three-way forward built from two 2:1 stages; the EX/MEM stage sits last so it wins.
   mux2_n #(.N(N)) u_a_wb (
      .sel_i (sel_a == FwdMemWb),
      .d0_i  (rs1_data_q),
      .d1_i  (memwb_result),
      .y_o   (a_wb)
   );

   mux2_n #(.N(N)) u_a_ex (
      .sel_i (sel_a == FwdExMem),
      .d0_i  (a_wb),
      .d1_i  (exmem_result),
      .y_o   (fwd_a)
   );

   mux2_n #(.N(N)) u_b_wb (
      .sel_i (sel_b == FwdMemWb),
      .d0_i  (rs2_data_q),
      .d1_i  (memwb_result),
      .y_o   (b_wb)
   );

   mux2_n #(.N(N)) u_b_ex (
      .sel_i (sel_b == FwdExMem),
      .d0_i  (b_wb),
      .d1_i  (exmem_result),
      .y_o   (fwd_b)
   );

   mux2_n #(.N(N)) u_b_src (
      .sel_i (alu_src_q),
      .d0_i  (fwd_b),
      .d1_i  (imm_q),
      .y_o   (alu_b)
   );

   assign alu_a           = fwd_a;
   assign store_data      = fwd_b;
   assign alu_control_out = alu_control_q;
   assign rd_out          = rd_q;
   assign valid_out       = valid_q;
   assign reg_write_out   = reg_write_q & valid_q;
   assign mem_read_out    = mem_read_q & valid_q;
   assign mem_write_out   = mem_write_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table for the hazard/forwarding corners, then random
// stimulus checked against a slot-level reference model.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result;
   logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
   logic [3:0]  id_alu_control;
   logic        branch_flush, exmem_reg_write, memwb_reg_write;
   logic [31:0] alu_a, alu_b, store_data;
   logic [3:0]  alu_control_out;
   logic [4:0]  rd_out;
   logic        reg_write_out, mem_read_out, mem_write_out, valid_out, stall_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.N(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_rs1_data     (id_rs1_data),
      .id_rs2_data     (id_rs2_data),
      .id_imm          (id_imm),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rd           (id_rd),
      .id_alu_control  (id_alu_control),
      .id_alu_src      (id_alu_src),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .id_mem_write    (id_mem_write),
      .branch_flush    (branch_flush),
      .exmem_reg_write (exmem_reg_write),
      .memwb_reg_write (memwb_reg_write),
      .exmem_rd        (exmem_rd),
      .memwb_rd        (memwb_rd),
      .exmem_result    (exmem_result),
      .memwb_result    (memwb_result),
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .alu_control_out (alu_control_out),
      .store_data      (store_data),
      .rd_out          (rd_out),
      .reg_write_out   (reg_write_out),
      .mem_read_out    (mem_read_out),
      .mem_write_out   (mem_write_out),
      .valid_out       (valid_out),
      .stall_out       (stall_out)
   );

   typedef struct {
      logic        rst, flush, idv;
      logic [31:0] rs1d, rs2d, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  op;
      logic        src, rw, mr, mw;
      logic        exw, mww;
      logic [4:0]  exrd, mwrd;
      logic [31:0] exres, mwres;
      logic [31:0] ea, eb, esd;
      logic        ev, erw, emr, emw, est;
   } vec_t;

   // Instruction held by the stage, as the model understands it.
   typedef struct {
      logic        v;
      logic [31:0] a, b, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  op;
      logic        src, rw, mr, mw;
   } slot_t;

   slot_t m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] d);
      if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
      if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
      return d;
   endfunction

   function automatic logic hazard();
      return m.v && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
   endfunction

   task automatic check_model();
      chk("model alu_a", alu_a, fwd(m.rs1, m.a));
      chk("model alu_b", alu_b, m.src ? m.imm : fwd(m.rs2, m.b));
      chk("model store_data", store_data, fwd(m.rs2, m.b));
      chk("model alu_control", 32'(alu_control_out), 32'(m.op));
      chk("model rd_out", 32'(rd_out), 32'(m.rd));
      chk("model valid", 32'(valid_out), 32'(m.v));
      chk("model reg_write", 32'(reg_write_out), 32'(m.rw & m.v));
      chk("model mem_read", 32'(mem_read_out), 32'(m.mr & m.v));
      chk("model mem_write", 32'(mem_write_out), 32'(m.mw & m.v));
      chk("model stall", 32'(stall_out), 32'(hazard() && !branch_flush));
   endtask

   task automatic model_update();
      if (rst || branch_flush || hazard()) begin
         m = '{default: '0};
      end else begin
         m.v = id_valid;   m.a = id_rs1_data; m.b = id_rs2_data; m.imm = id_imm;
         m.rs1 = id_rs1;   m.rs2 = id_rs2;    m.rd = id_rd;      m.op = id_alu_control;
         m.src = id_alu_src; m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
      end
   endtask

   task automatic drive(input vec_t t);
      rst = t.rst;  branch_flush = t.flush;  id_valid = t.idv;
      id_rs1_data = t.rs1d;  id_rs2_data = t.rs2d;  id_imm = t.imm;
      id_rs1 = t.rs1;  id_rs2 = t.rs2;  id_rd = t.rd;  id_alu_control = t.op;
      id_alu_src = t.src;  id_reg_write = t.rw;  id_mem_read = t.mr;  id_mem_write = t.mw;
      exmem_reg_write = t.exw;  exmem_rd = t.exrd;  exmem_result = t.exres;
      memwb_reg_write = t.mww;  memwb_rd = t.mwrd;  memwb_result = t.mwres;
   endtask

   function automatic vec_t ins(input logic [4:0] rs1, input logic [31:0] rs1d,
                                input logic [4:0] rs2, input logic [31:0] rs2d,
                                input logic [31:0] imm, input logic [4:0] rd,
                                input logic src, input logic rw, input logic mr, input logic mw);
      vec_t t = '{default: '0};
      t.idv = 1'b1; t.rs1 = rs1; t.rs1d = rs1d; t.rs2 = rs2; t.rs2d = rs2d; t.imm = imm;
      t.rd = rd; t.op = AluAdd; t.src = src; t.rw = rw; t.mr = mr; t.mw = mw;
      return t;
   endfunction

   function automatic vec_t ex(input vec_t t, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] sd, input logic v, input logic rw,
                               input logic mr, input logic mw, input logic st);
      t.ea = a; t.eb = b; t.esd = sd; t.ev = v; t.erw = rw; t.emr = mr; t.emw = mw; t.est = st;
      return t;
   endfunction

   vec_t vecs[$];

   initial begin
      vec_t idle, plain, dm, x0, lw, add4, st, t;
      idle  = '{default: '0};
      plain = ins(1, 5, 2, 0, 7, 3, 1, 1, 0, 0);
      dm    = ins(3, 'h11, 0, 0, 0, 5, 0, 0, 0, 0);
      x0    = ins(0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      lw    = ins(1, 'h100, 2, 0, 8, 4, 1, 1, 1, 0);
      add4  = ins(4, 1, 2, 9, 0, 6, 0, 1, 0, 0);
      st    = ins(2, 'h20, 3, 'h33, 4, 0, 1, 0, 0, 1);

      // Each entry: inputs for the cycle, outputs expected before the next edge.
      vecs.push_back(ex(plain, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(ex(dm, 5, 7, 0, 1, 1, 0, 0, 0));
      t = dm; t.exw = 1; t.exrd = 3; t.exres = 'hAA; t.mww = 1; t.mwrd = 3; t.mwres = 'hBB;
      vecs.push_back(ex(t, 'hAA, 0, 0, 1, 0, 0, 0, 0));
      t = x0; t.mww = 1; t.mwrd = 3; t.mwres = 'hBB;
      vecs.push_back(ex(t, 'hBB, 0, 0, 1, 0, 0, 0, 0));
      t = lw; t.exw = 1; t.exrd = 0; t.exres = 'hFFFF_FFFF;
      vecs.push_back(ex(t, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(ex(add4, 'h100, 8, 0, 1, 1, 1, 0, 1));
      vecs.push_back(ex(add4, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(ex(lw, 1, 9, 9, 1, 1, 0, 0, 0));
      t = add4; t.flush = 1;
      vecs.push_back(ex(t, 'h100, 8, 0, 1, 1, 1, 0, 0));
      vecs.push_back(ex(st, 0, 0, 0, 0, 0, 0, 0, 0));
      t = plain; t.rst = 1;
      vecs.push_back(ex(t, 'h20, 4, 'h33, 1, 0, 0, 1, 0));
      vecs.push_back(ex(plain, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(ex(idle, 5, 7, 0, 1, 1, 0, 0, 0));

      drive(idle);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      m = '{default: '0};
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i]);
         #1;
         chk($sformatf("vec%0d alu_a", i), alu_a, vecs[i].ea);
         chk($sformatf("vec%0d alu_b", i), alu_b, vecs[i].eb);
         chk($sformatf("vec%0d store_data", i), store_data, vecs[i].esd);
         chk($sformatf("vec%0d valid", i), 32'(valid_out), 32'(vecs[i].ev));
         chk($sformatf("vec%0d reg_write", i), 32'(reg_write_out), 32'(vecs[i].erw));
         chk($sformatf("vec%0d mem_read", i), 32'(mem_read_out), 32'(vecs[i].emr));
         chk($sformatf("vec%0d mem_write", i), 32'(mem_write_out), 32'(vecs[i].emw));
         chk($sformatf("vec%0d stall", i), 32'(stall_out), 32'(vecs[i].est));
         check_model();
         @(posedge clk);
         model_update();
         #1;
      end

      for (int i = 0; i < 500; i++) begin
         rst             = ($urandom_range(0, 49) == 0);
         branch_flush    = ($urandom_range(0, 9) == 0);
         id_valid        = ($urandom_range(0, 3) != 0);
         id_rs1_data     = $urandom;
         id_rs2_data     = $urandom;
         id_imm          = $urandom;
         id_rs1          = 5'($urandom_range(0, 7));
         id_rs2          = 5'($urandom_range(0, 7));
         id_rd           = 5'($urandom_range(0, 7));
         id_alu_control  = 4'($urandom_range(0, 9));
         id_alu_src      = 1'($urandom_range(0, 1));
         id_reg_write    = 1'($urandom_range(0, 1));
         id_mem_read     = ($urandom_range(0, 2) == 0);
         id_mem_write    = 1'($urandom_range(0, 1));
         exmem_reg_write = 1'($urandom_range(0, 1));
         memwb_reg_write = 1'($urandom_range(0, 1));
         exmem_rd        = 5'($urandom_range(0, 7));
         memwb_rd        = 5'($urandom_range(0, 7));
         exmem_result    = $urandom;
         memwb_result    = $urandom;
         #1;
         check_model();
         @(posedge clk);
         model_update();
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
